cache_dm_fill: RTL and testbench
================================

CACHE_DM_FILL -- requirements
Module: cache_dm_fill

Interface
REQ-001 SHALL have parameter INDEX_W, default 5, giving 2^INDEX_W lines.
REQ-002 SHALL have parameter OFFSET_W, default 1, giving 2^OFFSET_W 16-bit words per line (1..3 legal); tag = addr[15:INDEX_W+OFFSET_W].
REQ-003 SHALL have ports:
 clk  input  1  clock; all state on rising edge
 rstz  input  1  reset, asynchronous, active-low
 req  input  1  CPU request; addr/we/wdata held stable until ready
 we  input  1  1 = store, 0 = load
 addr  input  16  CPU word address
 wdata  input  16  store data
 rdata  output  16  load data, valid when ready & !we
 ready  output  1  transfer complete this cycle (combinational)
 mem_req  output  1  memory request, held until mem_ack
 mem_we  output  1  memory write strobe
 mem_addr  output  16  memory word address
 mem_wdata  output  16  memory write data
 mem_rdata  input  16  memory read data, valid with mem_ack
 mem_ack  input  1  one-cycle memory completion
 hit_cnt  output  16  load hit count
 miss_cnt  output  16  load miss count

Function
REQ-004 SHALL be direct-mapped, write-through, no-write-allocate; per line: valid bit, tag, 2^OFFSET_W data words.
REQ-005 SHALL implement FSM states IDLE, FILL, WRITE.
REQ-006 IDLE, req & !we & hit: ready=1 the same cycle, rdata = addressed word, no memory access.
REQ-007 IDLE, req & !we & miss: next state FILL, line valid cleared, fill word counter = 0, line tag written.
REQ-008 FILL: mem_req=1, mem_we=0, mem_addr = {addr[15:OFFSET_W], counter}; on mem_ack, store mem_rdata in word[counter] and increment the counter.
REQ-009 On the ack of the last word, valid SHALL be set and the FSM SHALL return to IDLE; the retried load then hits (ready) on the following cycle.
REQ-010 IDLE, req & we: next state WRITE; WRITE drives mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata; ready = mem_ack; on ack, return to IDLE.
REQ-011 On the WRITE ack, if the line hits, the cached word SHALL be updated with wdata; on a miss, the cache SHALL be unchanged.
REQ-012 mem_ack outside FILL/WRITE SHALL be ignored; mem_req SHALL be 0 in IDLE.
REQ-013 A started fill or write SHALL complete even if req deasserts.
REQ-014 A partially filled line SHALL never produce a hit.
REQ-015 ready SHALL be 0 whenever req=0; rdata SHALL be 0 when not ready.

Reset
REQ-016 rstz low SHALL immediately force: state IDLE, all valid bits 0, counter 0, mem_req 0, ready 0, hit_cnt/miss_cnt 0.
REQ-017 Reset SHALL NOT be required to clear tag or data arrays.
REQ-018 Reset during FILL or WRITE SHALL abandon the transfer; the line SHALL remain invalid.

Configuration
REQ-019 With macro CACHE_STATS_EN defined, hit_cnt SHALL increment on each REQ-006 cycle, miss_cnt SHALL increment on each IDLE->FILL transition, and both SHALL saturate at 0xFFFF.
REQ-020 Without CACHE_STATS_EN, hit_cnt and miss_cnt SHALL be constant 0, with no counter logic.

Verification (defaults; index = addr[5:1])
REQ-021 After reset, load 0x0040; ack mem_rdata 0x1111 @0x0040 and 0x2222 @0x0041 -> two mem reads, then ready with rdata=0x1111; load 0x0041 -> ready same cycle, rdata=0x2222, mem_req stays 0.
REQ-022 Store 0x0041=0xBEEF (hit) -> mem write 0x0041/0xBEEF, ready on ack; load 0x0041 -> zero-wait hit, rdata=0xBEEF.
REQ-023 Store 0x0100=0x1234 (miss) -> one mem write; following load 0x0100 -> FILL (no allocation occurred).
REQ-024 Load 0x0080 after REQ-021 (same index 0, tag 2) -> FILL; then load 0x0040 -> miss and FILL.
REQ-025 Reset after the first fill ack of load 0x0040 -> mem_req=0 immediately; post-reset load 0x0040 -> miss.
REQ-026 With CACHE_STATS_EN, after REQ-021 -> hit_cnt=2, miss_cnt=1; without it -> both 0.

Source files
------------

// File: rtl/cache_dm_fill.sv
// Direct-mapped, write-through, no-write-allocate cache with a multi-word line fill engine.
// Optional load hit/miss counters are built only when CACHE_STATS_EN is defined.
module cache_dm_fill #(
   parameter int INDEX_W  = 5,
   parameter int OFFSET_W = 1
) (
   input  logic        clk,
   input  logic        rstz,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
);

   localparam int LINES = 1 << INDEX_W;
   localparam int WORDS = 1 << OFFSET_W;
   localparam int TAG_W = 16 - INDEX_W - OFFSET_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [OFFSET_W-1:0] cnt_q, cnt_d;
   logic [15:0]         addr_q, wdata_q;
   logic [LINES-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_q  [LINES];
   logic [15:0]         data_q [LINES][WORDS];

   logic [INDEX_W-1:0]  req_idx, cur_idx;
   logic [OFFSET_W-1:0] req_off, cur_off;
   logic [TAG_W-1:0]    req_tag, cur_tag;
   logic                req_hit, cur_hit;
   logic                hit_event, miss_event, fill_ack, fill_last, write_ack;

   assign req_idx = addr[INDEX_W+OFFSET_W-1:OFFSET_W];
   assign req_off = addr[OFFSET_W-1:0];
   assign req_tag = addr[15:INDEX_W+OFFSET_W];
   assign cur_idx = addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
   assign cur_off = addr_q[OFFSET_W-1:0];
   assign cur_tag = addr_q[15:INDEX_W+OFFSET_W];

   assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign cur_hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

   assign hit_event  = (state_q == S_IDLE) && req && !we && req_hit;
   assign miss_event = (state_q == S_IDLE) && req && !we && !req_hit;
   assign fill_ack   = (state_q == S_FILL) && mem_ack;
   assign fill_last  = fill_ack && (cnt_q == '1);
   assign write_ack  = (state_q == S_WRITE) && mem_ack;

   // Transfers run from the address/data captured at request time, so they
   // still complete correctly if the CPU drops req mid-transfer.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ready     = 1'b0;
      rdata     = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (we) begin
                  state_d = S_WRITE;
               end else if (req_hit) begin
                  ready = 1'b1;
                  rdata = data_q[req_idx][req_off];
               end else begin
                  state_d = S_FILL;
                  cnt_d   = '0;
               end
            end
         end
         S_FILL: begin
            mem_req  = 1'b1;
            mem_addr = {addr_q[15:OFFSET_W], cnt_q};
            if (mem_ack) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == '1) state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            ready     = mem_ack && req;
            if (mem_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == S_IDLE && req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (miss_event) valid_q[req_idx] <= 1'b0;
         if (fill_last)  valid_q[cur_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (miss_event) tag_q[req_idx] <= req_tag;
      if (fill_ack) data_q[cur_idx][cnt_q] <= mem_rdata;
      if (write_ack && cur_hit) data_q[cur_idx][cur_off] <= wdata_q;
   end

`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit_event && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
         if (miss_event && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_dm_fill.sv
// Directed bench for cache_dm_fill: vector table of CPU accesses against a memory model,
// plus hand sequences for reset mid-fill, stray acks and req dropped during a fill.
module tb_cache_dm_fill;

   logic        clk = 1'b0;
   logic        rstz;
   logic        req, we;
   logic [15:0] addr, wdata, rdata;
   logic        ready;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;
   logic [15:0] hit_cnt, miss_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_hits = 0;
   int exp_miss = 0;

   logic [15:0] mem [1024];

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [15:0] wd;
      logic [15:0] exp_rd;
      int          exp_rds;
      int          exp_wrs;
   } vec_t;

   localparam int NV = 16;
   vec_t tv [NV];

   cache_dm_fill #(.INDEX_W(5), .OFFSET_W(1)) dut (
      .clk(clk), .rstz(rstz), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_stats(input string nm);
`ifdef CACHE_STATS_EN
      chk({nm, " hit_cnt"}, {16'h0, hit_cnt}, exp_hits);
      chk({nm, " miss_cnt"}, {16'h0, miss_cnt}, exp_miss);
`else
      chk({nm, " hit_cnt"}, {16'h0, hit_cnt}, 32'd0);
      chk({nm, " miss_cnt"}, {16'h0, miss_cnt}, 32'd0);
`endif
   endtask

   // One CPU access; the bench answers every memory request with an immediate ack.
   task automatic access(input logic w, input logic [15:0] a, input logic [15:0] wd,
                         output logic [15:0] rd, output int waits, output int nrd,
                         output int nwr, output int bad, output bit timeout);
      logic [15:0] ea;
      bit done;
      rd = '0; waits = 0; nrd = 0; nwr = 0; bad = 0; done = 1'b0;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = wd;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (mem_req) begin
            if (mem_we) begin
               nwr++;
               if (!w || mem_addr !== a || mem_wdata !== wd) bad++;
               mem[mem_addr[9:0]] = mem_wdata;
               mem_rdata = '0;
            end else begin
               ea = {a[15:1], nrd[0]};
               if (w || mem_addr !== ea) bad++;
               nrd++;
               mem_rdata = mem[mem_addr[9:0]];
            end
            mem_ack = 1'b1;
            #1;
         end
         if (ready) begin
            if (!w && mem_req) bad++;
            rd = rdata;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         mem_rdata = '0;
         if (done) break;
         waits++;
         @(negedge clk);
      end
      req = 1'b0; we = 1'b0;
      timeout = !done;
   endtask

   initial begin
      logic [15:0] rd;
      int waits, nrd, nwr, bad, n, exp_waits;
      bit to;

      for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'h5A00;
      mem[16'h040] = 16'h1111; mem[16'h041] = 16'h2222;
      mem[16'h080] = 16'hAAAA; mem[16'h081] = 16'hBBBB;
      mem[16'h101] = 16'h6666;

      tv[0]  = '{1'b0, 16'h0040, 16'h0000, 16'h1111, 2, 0};
      tv[1]  = '{1'b0, 16'h0041, 16'h0000, 16'h2222, 0, 0};
      tv[2]  = '{1'b1, 16'h0041, 16'hBEEF, 16'h0000, 0, 1};
      tv[3]  = '{1'b0, 16'h0041, 16'h0000, 16'hBEEF, 0, 0};
      tv[4]  = '{1'b1, 16'h0100, 16'h1234, 16'h0000, 0, 1};
      tv[5]  = '{1'b0, 16'h0100, 16'h0000, 16'h1234, 2, 0};
      tv[6]  = '{1'b0, 16'h0080, 16'h0000, 16'hAAAA, 2, 0};
      tv[7]  = '{1'b0, 16'h0040, 16'h0000, 16'h1111, 2, 0};
      tv[8]  = '{1'b0, 16'h0041, 16'h0000, 16'hBEEF, 0, 0};
      tv[9]  = '{1'b0, 16'h0081, 16'h0000, 16'hBBBB, 2, 0};
      tv[10] = '{1'b0, 16'h0002, 16'h0000, 16'h5A02, 2, 0};
      tv[11] = '{1'b1, 16'h0003, 16'h0F0F, 16'h0000, 0, 1};
      tv[12] = '{1'b0, 16'h0003, 16'h0000, 16'h0F0F, 0, 0};
      tv[13] = '{1'b0, 16'h0002, 16'h0000, 16'h5A02, 0, 0};
      tv[14] = '{1'b0, 16'hFFFF, 16'h0000, 16'h59FF, 2, 0};
      tv[15] = '{1'b0, 16'hFFFE, 16'h0000, 16'h59FE, 0, 0};

      rstz = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset mem_req", {31'h0, mem_req}, 32'd0);
      chk("reset ready", {31'h0, ready}, 32'd0);
      chk("reset rdata", {16'h0, rdata}, 32'd0);
      chk_stats("reset");
      @(negedge clk);
      rstz = 1'b1;

      for (int i = 0; i < NV; i++) begin
         access(tv[i].w, tv[i].a, tv[i].wd, rd, waits, nrd, nwr, bad, to);
         if (!tv[i].w) begin
            exp_hits++;
            if (tv[i].exp_rds > 0) exp_miss++;
         end
         exp_waits = tv[i].w ? 1 : (tv[i].exp_rds == 0 ? 0 : 1 + tv[i].exp_rds);
         chk($sformatf("v%0d timeout", i), {31'h0, to}, 32'd0);
         if (!tv[i].w) chk($sformatf("v%0d rdata", i), {16'h0, rd}, {16'h0, tv[i].exp_rd});
         chk($sformatf("v%0d mem reads", i), nrd, tv[i].exp_rds);
         chk($sformatf("v%0d mem writes", i), nwr, tv[i].exp_wrs);
         chk($sformatf("v%0d wait cycles", i), waits, exp_waits);
         chk($sformatf("v%0d bus protocol", i), bad, 32'd0);
         chk_stats($sformatf("v%0d", i));
      end

      // Load miss whose req drops once the fill has started: fill still completes.
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 16'h0200;
      @(posedge clk);
      #1;
      req = 1'b0;
      exp_miss++;
      n = 0; bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         if (!mem_req) break;
         if (ready || mem_we || mem_addr !== {15'h0100, n[0]}) bad++;
         mem_rdata = mem[mem_addr[9:0]];
         mem_ack = 1'b1;
         n++;
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
      end
      chk("dropped-req fill reads", n, 32'd2);
      chk("dropped-req fill bus", bad, 32'd0);

      // Stray ack in IDLE must be ignored.
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      chk("idle ack mem_req", {31'h0, mem_req}, 32'd0);
      chk("idle ack ready", {31'h0, ready}, 32'd0);
      @(posedge clk);
      #1;
      mem_ack = 1'b0;

      access(1'b0, 16'h0201, 16'h0, rd, waits, nrd, nwr, bad, to);
      exp_hits++;
      chk("after dropped-req rdata", {16'h0, rd}, 32'h5801);
      chk("after dropped-req reads", nrd, 32'd0);
      chk("after dropped-req waits", waits, 32'd0);
      chk_stats("after dropped-req");

      // Reset after the first fill ack abandons the fill.
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 16'h0040;
      @(negedge clk);
      #1;
      chk("mid-fill first mem_req", {31'h0, mem_req}, 32'd1);
      mem_rdata = mem[mem_addr[9:0]];
      mem_ack = 1'b1;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      @(negedge clk);
      #1;
      chk("mid-fill second mem_req", {31'h0, mem_req}, 32'd1);
      rstz = 1'b0;
      #1;
      exp_hits = 0; exp_miss = 0;
      chk("reset mid-fill mem_req", {31'h0, mem_req}, 32'd0);
      chk("reset mid-fill ready", {31'h0, ready}, 32'd0);
      chk_stats("reset mid-fill");
      req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstz = 1'b1;

      access(1'b0, 16'h0040, 16'h0, rd, waits, nrd, nwr, bad, to);
      exp_hits++; exp_miss++;
      chk("post-reset load timeout", {31'h0, to}, 32'd0);
      chk("post-reset load reads", nrd, 32'd2);
      chk("post-reset load rdata", {16'h0, rd}, 32'h1111);
      access(1'b0, 16'h0041, 16'h0, rd, waits, nrd, nwr, bad, to);
      exp_hits++;
      chk("post-reset hit rdata", {16'h0, rd}, 32'hBEEF);
      chk("post-reset hit reads", nrd, 32'd0);
      chk_stats("post-reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
